// File: rtl/arb_2to1_pkg.sv
// Shared sizes, logic levels and FSM encoding for the 2:1 message arbiter.
package arb_2to1_pkg;

  localparam int NS_ADDRESS_SIZE = 4;
  localparam int NS_DATA_SIZE    = 8;
  localparam int NS_REDUN_SIZE   = 4;

  localparam logic NS_ON  = 1'b1;
  localparam logic NS_OFF = 1'b0;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CHK      = 3'd1,
    SEND     = 3'd2,
    WAIT_OUT = 3'd3,
    ACK_IN   = 3'd4
  } state_t;

endpackage

// File: rtl/arb_2to1_if.sv
// One message channel. Four-phase handshake: the sender raises req with all
// fields stable, the receiver raises ack, the sender drops req, the receiver drops ack.
interface arb_2to1_if
  import arb_2to1_pkg::*;
#(
  parameter int ASZ = NS_ADDRESS_SIZE,
  parameter int DSZ = NS_DATA_SIZE,
  parameter int RSZ = NS_REDUN_SIZE
) ();

  logic [ASZ-1:0] src;
  logic [ASZ-1:0] dst;
  logic [DSZ-1:0] dat;
  logic [RSZ-1:0] red;
  logic           req;
  logic           ack;

  modport master (output src, dst, dat, red, req, input ack);
  modport slave  (input src, dst, dat, red, req, output ack);

endinterface

// File: rtl/arb_2to1_calc_redun.sv
// Redundancy code: bit b is the XOR of every bit of {src,dst,dat} whose index is b modulo RSZ.
module calc_redun
  import arb_2to1_pkg::*;
#(
  parameter int ASZ = NS_ADDRESS_SIZE,
  parameter int DSZ = NS_DATA_SIZE,
  parameter int RSZ = NS_REDUN_SIZE
) (
  input  logic [ASZ-1:0] src,
  input  logic [ASZ-1:0] dst,
  input  logic [DSZ-1:0] dat,
  output logic [RSZ-1:0] red
);

  localparam int W = 2 * ASZ + DSZ;

  logic [W-1:0] flat;
  assign flat = {src, dst, dat};

  always_comb begin
    red = '0;
    for (int b = 0; b < RSZ; b++) begin
      for (int k = b; k < W; k += RSZ) begin
        red[b] = red[b] ^ flat[k];
      end
    end
  end

endmodule

// File: rtl/arb_2to1.sv
// Round-robin 2:1 arbiter: grants one requester, checks its redundancy code,
// forwards good messages on o0 and drops corrupted ones after acknowledging them.
module arb_2to1
  import arb_2to1_pkg::*;
#(
  parameter int ASZ = NS_ADDRESS_SIZE,
  parameter int DSZ = NS_DATA_SIZE,
  parameter int RSZ = NS_REDUN_SIZE
) (
  input  logic        clk,
  input  logic        reset,
  arb_2to1_if.slave   i0,
  arb_2to1_if.slave   i1,
  arb_2to1_if.master  o0,
  output logic [3:0]  dbg_leds,
  output logic [3:0]  dbg_disp0,
  output logic [3:0]  dbg_disp1,
  output state_t      dbg_state
);

  state_t         state_q, state_d;
  logic           gnt_q, gnt_d;
  logic           last_gnt_q, last_gnt_d;
  logic [ASZ-1:0] lat_src_q, lat_src_d, lat_dst_q, lat_dst_d;
  logic [DSZ-1:0] lat_dat_q, lat_dat_d;
  logic [RSZ-1:0] lat_red_q, lat_red_d;
  logic [ASZ-1:0] o_src_q, o_src_d, o_dst_q, o_dst_d;
  logic [DSZ-1:0] o_dat_q, o_dat_d;
  logic [RSZ-1:0] o_red_q, o_red_d;
  logic           o_req_q, o_req_d;
  logic [1:0]     ack_q, ack_d;
  logic [3:0]     cnt0_q, cnt0_d, cnt1_q, cnt1_d;
  logic           err_red_q, err_red_d;
  logic           err_proto_q, err_proto_d;
  logic [RSZ-1:0] calc_red;
  logic           gnt_req;

  calc_redun #(.ASZ(ASZ), .DSZ(DSZ), .RSZ(RSZ)) u_calc_redun (
    .src (lat_src_q),
    .dst (lat_dst_q),
    .dat (lat_dat_q),
    .red (calc_red)
  );

  assign gnt_req = gnt_q ? i1.req : i0.req;

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    last_gnt_d  = last_gnt_q;
    lat_src_d   = lat_src_q;
    lat_dst_d   = lat_dst_q;
    lat_dat_d   = lat_dat_q;
    lat_red_d   = lat_red_q;
    o_src_d     = o_src_q;
    o_dst_d     = o_dst_q;
    o_dat_d     = o_dat_q;
    o_red_d     = o_red_q;
    o_req_d     = o_req_q;
    ack_d       = ack_q;
    cnt0_d      = cnt0_q;
    cnt1_d      = cnt1_q;
    err_red_d   = err_red_q;
    err_proto_d = err_proto_q;
    case (state_q)
      IDLE: begin
        if (o0.ack) err_proto_d = NS_ON;
        if (i0.req || i1.req) begin
          // On a tie the requester that was not served last wins.
          gnt_d     = (i0.req && i1.req) ? ~last_gnt_q : i1.req;
          lat_src_d = gnt_d ? i1.src : i0.src;
          lat_dst_d = gnt_d ? i1.dst : i0.dst;
          lat_dat_d = gnt_d ? i1.dat : i0.dat;
          lat_red_d = gnt_d ? i1.red : i0.red;
          state_d   = CHK;
        end
      end
      CHK: begin
        if (o0.ack) err_proto_d = NS_ON;
        if (calc_red == lat_red_q) begin
          o_src_d = lat_src_q;
          o_dst_d = lat_dst_q;
          o_dat_d = lat_dat_q;
          o_red_d = lat_red_q;
          o_req_d = NS_ON;
          state_d = SEND;
        end else begin
          // Corrupted message: acknowledge the sender but never forward it.
          err_red_d    = NS_ON;
          ack_d[gnt_q] = NS_ON;
          state_d      = ACK_IN;
        end
      end
      SEND: begin
        if (o0.ack) begin
          o_req_d = NS_OFF;
          state_d = WAIT_OUT;
        end
      end
      WAIT_OUT: begin
        if (!o0.ack) begin
          ack_d[gnt_q] = NS_ON;
          if (gnt_q) cnt1_d = cnt1_q + 4'd1;
          else       cnt0_d = cnt0_q + 4'd1;
          state_d = ACK_IN;
        end
      end
      ACK_IN: begin
        if (!gnt_req) begin
          ack_d[gnt_q] = NS_OFF;
          last_gnt_d   = gnt_q;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      gnt_q       <= 1'b1;
      last_gnt_q  <= 1'b1;
      lat_src_q   <= '0;
      lat_dst_q   <= '0;
      lat_dat_q   <= '0;
      lat_red_q   <= '0;
      o_src_q     <= '0;
      o_dst_q     <= '0;
      o_dat_q     <= '0;
      o_red_q     <= '0;
      o_req_q     <= NS_OFF;
      ack_q       <= '0;
      cnt0_q      <= '0;
      cnt1_q      <= '0;
      err_red_q   <= NS_OFF;
      err_proto_q <= NS_OFF;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      last_gnt_q  <= last_gnt_d;
      lat_src_q   <= lat_src_d;
      lat_dst_q   <= lat_dst_d;
      lat_dat_q   <= lat_dat_d;
      lat_red_q   <= lat_red_d;
      o_src_q     <= o_src_d;
      o_dst_q     <= o_dst_d;
      o_dat_q     <= o_dat_d;
      o_red_q     <= o_red_d;
      o_req_q     <= o_req_d;
      ack_q       <= ack_d;
      cnt0_q      <= cnt0_d;
      cnt1_q      <= cnt1_d;
      err_red_q   <= err_red_d;
      err_proto_q <= err_proto_d;
    end
  end

  assign o0.src = o_src_q;
  assign o0.dst = o_dst_q;
  assign o0.dat = o_dat_q;
  assign o0.red = o_red_q;
  assign o0.req = o_req_q;
  assign i0.ack = ack_q[0];
  assign i1.ack = ack_q[1];

  // Outside IDLE gnt_q is the live grant; in IDLE it equals the last grant.
  assign dbg_leds  = {state_q != IDLE, gnt_q, err_proto_q, err_red_q};
  assign dbg_disp0 = cnt0_q;
  assign dbg_disp1 = cnt1_q;
  assign dbg_state = state_q;

endmodule

// File: doc/arb_2to1.md
ARB_2TO1 -- requirements
Module: arb_2to1

Interface
REQ-001 SHALL have parameter ASZ, default NS_ADDRESS_SIZE, address width of src/dst fields.
REQ-002 SHALL have parameter DSZ, default NS_DATA_SIZE, data width.
REQ-003 SHALL have parameter RSZ, default NS_REDUN_SIZE, redundancy width.
REQ-004 SHALL have port clk  in  1  sole clock, all logic on rising edge.
REQ-005 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-006 SHALL have input channel i0 (i0_src ASZ, i0_dst ASZ, i0_dat DSZ, i0_red RSZ, i0_req 1 in; i0_ack 1 out), requester 0.
REQ-007 SHALL have input channel i1, same fields and directions as i0, requester 1.
REQ-008 SHALL have output channel o0 (o0_src, o0_dst, o0_dat, o0_red, o0_req out; o0_ack in), merged stream.
REQ-009 SHALL have dbg_leds  out  4  status; dbg_disp0  out  4  i0 forward count; dbg_disp1  out  4  i1 forward count.

Function
REQ-010 SHALL implement a four-phase req/ack handshake on every channel: req rises with data stable, ack rises, req falls, ack falls.
REQ-011 SHALL use FSM states IDLE, CHK, SEND, WAIT_OUT, ACK_IN.
REQ-012 IDLE: if any ix_req high, SHALL grant one input, latch its src/dst/dat/red into internal regs, go to CHK.
REQ-013 Both reqs high in IDLE: SHALL grant the input other than last_gnt (round-robin); single req: grant it regardless of last_gnt.
REQ-014 CHK: SHALL compare latched red with redundancy computed over latched src/dst/dat; match -> set o0_req, go SEND; mismatch -> set sticky err_red, go ACK_IN (message dropped, never forwarded).
REQ-015 SEND: o0_* data SHALL equal latched message unchanged; on o0_ack high, clear o0_req, go WAIT_OUT.
REQ-016 WAIT_OUT: on o0_ack low, set granted ix_ack, increment that input's 4-bit forward counter (wraps 15->0), go ACK_IN.
REQ-017 ACK_IN: on granted ix_req low, clear ix_ack, set last_gnt to granted index, go IDLE.
REQ-018 All outputs SHALL be registered; minimum latency ix_req sampled high -> o0_req high = 2 clk edges.
REQ-019 Non-granted input's ack SHALL stay low; its req SHALL remain pending without loss.
REQ-020 o0_ack high while in IDLE or CHK SHALL be ignored and SHALL set sticky err_proto.
REQ-021 dbg_leds[0]=err_red, [1]=err_proto, [2]=current/last grant index, [3]=1 when state != IDLE.
REQ-022 dbg_disp0/dbg_disp1 SHALL show i0/i1 forward counters; dropped messages not counted.

Reset
REQ-023 Reset SHALL asynchronously force: state IDLE, o0_req/i0_ack/i1_ack 0, o0_src/dst/dat/red 0, err_red/err_proto 0, counters 0, last_gnt 1 (i0 wins first tie).
REQ-024 Reset mid-transfer SHALL abort the message; no partial handshake resumes after release.
REQ-025 First grant SHALL occur on first rising clk edge after reset deasserts with a req high.

Structure
REQ-026 NS_ADDRESS_SIZE, NS_DATA_SIZE, NS_REDUN_SIZE, NS_ON/NS_OFF and channel declare/assign macros SHALL come from the shared hglobal include; FSM state encodings SHALL be local params.
REQ-027 Redundancy SHALL be computed by one instance of shared sub-module calc_redun on latched fields.

Verification
REQ-028 Single i0 msg (src 9, dst 1, dat 5, valid red) -> o0 carries identical fields, o0_req 2 edges after req, i0_ack only after o0_ack falls, dbg_disp0=1.
REQ-029 i0 and i1 req simultaneously after reset, held for 4 msgs each -> grant order i0,i1,i0,i1,...; both counters reach 4.
REQ-030 i1 msg with red field XOR 1 -> o0_req never rises, i1_ack completes handshake, dbg_leds[0]=1, dbg_disp1 unchanged.
REQ-031 Reset asserted while state SEND -> o0_req and all acks 0 immediately (before next edge); after release, fresh i0 msg forwards normally.
REQ-032 Inject o0_ack pulse in IDLE -> no output change, dbg_leds[1]=1 stays set until reset.
REQ-033 17 i0 msgs -> dbg_disp0 wraps to 1.
